ex_stage: RTL
=============

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 aluop_i  in  8  detailed op from ID/EX register (ALUOpBus codes).
REQ-004 alusel_i  in  3  result class: NOP/LOGIC/SHIFT/MOVE/ARITHMETIC/MUL.
REQ-005 reg1_i, reg2_i  in  32 each  operands; an immediate arrives in whichever operand ID did not read.
REQ-006 wd_i  in  5, wreg_i  in  1  destination register and write enable from ID.
REQ-007 hi_i, lo_i  in  32 each  committed HI/LO from the hilo register.
REQ-008 mem_whilo_i  in  1, mem_hi_i, mem_lo_i  in  32 each  HI/LO bypass from MEM.
REQ-009 wb_whilo_i  in  1, wb_hi_i, wb_lo_i  in  32 each  HI/LO bypass from WB.
REQ-010 wd_o  out  5, wreg_o  out  1, wdata_o  out  32  GPR write to EX/MEM and to the ID bypass.
REQ-011 whilo_o  out  1, hi_o, lo_o  out  32 each  HI/LO write request.
REQ-012 stallreq_o  out  1  pipeline stall request; ID/EX holds its inputs while it is 1.

Function
REQ-013 Outputs SHALL be combinational from the inputs and internal state; only the divider FSM, the MADD/MSUB phase bit and the 64-bit product temp SHALL be registered.
REQ-014 Effective HI/LO SHALL be taken from MEM bypass if mem_whilo_i=1, else from WB bypass if wb_whilo_i=1, else from hi_i/lo_i.
REQ-015 LOGIC: OR, AND, XOR, NOR of reg1_i and reg2_i; SHIFT: SLL/SRL/SRA of reg2_i by reg1_i[4:0].
REQ-016 ARITHMETIC: ADD/ADDU/ADDI/ADDIU = reg1+reg2 mod 2^32; SUB/SUBU = reg1-reg2; SLT signed, SLTU unsigned (result 0 or 1); CLZ/CLO = count of leading zeros/ones of reg1_i, 0..32.
REQ-017 ADD/ADDI/SUB signed overflow SHALL force wreg_o=0; the unsigned variants never suppress the write.
REQ-018 MOVE: MFHI/MFLO SHALL return the effective HI/LO; MOVN/MOVZ SHALL return reg1_i, with wreg_i passed through unchanged.
REQ-019 MUL: wdata_o = low 32 bits of the signed 64-bit product. MULT/MULTU: whilo_o=1 with {hi_o,lo_o} = signed/unsigned product.
REQ-020 MTHI: whilo_o=1, hi_o=reg1_i, lo_o=effective LO. MTLO: lo_o=reg1_i, hi_o=effective HI.
REQ-021 In all other cases wd_o=wd_i and wreg_o=wreg_i, and wdata_o is selected by alusel_i; NOP class gives 0.
REQ-022 MADD/MADDU/MSUB/MSUBU SHALL take two cycles.
REQ-023 MADD phase 0: latch the 64-bit product (signed for MADD/MSUB, unsigned for the U forms) into the temp; stallreq_o=1; whilo_o=0; set phase=1.
REQ-024 MADD phase 1: {hi_o,lo_o} = {effHI,effLO} plus the temp (MADD) or minus the temp (MSUB), mod 2^64; whilo_o=1; stallreq_o=0; set phase=0.
REQ-025 DIV/DIVU FSM states: IDLE, RUN, DONE.
REQ-026 IDLE with a DIV/DIVU op: stallreq_o=1. Next state is DONE with quotient=remainder=0 if reg2_i=0; otherwise RUN with cnt=0, operating on operand magnitudes (absolute values for DIV).
REQ-027 RUN: one restoring-division quotient bit per cycle, cnt increments each cycle, stallreq_o=1; after cnt=31 the next state is DONE.
REQ-028 DONE: apply signs (DIV only: quotient negated if the operand signs differ, remainder takes the dividend's sign); lo_o=quotient, hi_o=remainder, whilo_o=1, stallreq_o=0; next state unconditionally IDLE.
REQ-029 Latency: a nonzero divide holds stallreq_o=1 for exactly 33 cycles and whilo_o=1 in the 34th. A divide by zero stalls 1 cycle and writes in the 2nd.
REQ-030 Back-to-back divides: a DIV that appears in IDLE right after DONE SHALL start a fresh operation; operands are not reused.
REQ-031 Any non-DIV op seen in IDLE leaves the FSM in IDLE; madd phase and div state never advance simultaneously.

Reset
REQ-032 While rst=1, every output SHALL be 0, including stallreq_o.
REQ-033 rst=1 at a clock edge SHALL force FSM=IDLE, cnt=0, phase=0 and temp=0, aborting any operation in progress without writing HI/LO.

Verification
REQ-034 OR with reg1=0x00001234, reg2=0xFFFF0000, wreg_i=1, wd_i=5 -> wdata_o=0xFFFF1234, wreg_o=1, wd_o=5.
REQ-035 ADD with 0x7FFFFFFF + 0x00000001 -> wreg_o=0. The same operands with ADDU -> wdata_o=0x80000000, wreg_o=1.
REQ-036 DIV with reg1=0xFFFFFFF9 (-7), reg2=2 -> stallreq_o=1 for 33 cycles, then for one cycle lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, whilo_o=1.
REQ-037 DIVU with reg2=0 -> stallreq_o=1 for 1 cycle, then hi_o=lo_o=0 and whilo_o=1.
REQ-038 MADD with effHI=0, effLO=5, reg1=3, reg2=4 -> cycle 1: stallreq_o=1, whilo_o=0; cycle 2: hi_o=0, lo_o=17, whilo_o=1. MFHI with mem_whilo_i=1, mem_hi_i=0xA5A5A5A5, wb_whilo_i=1 -> wdata_o=0xA5A5A5A5.
REQ-039 rst pulsed in the 10th RUN cycle of a DIV -> outputs 0 during reset, FSM in IDLE afterwards, and no whilo_o pulse occurs.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO bypass, MUL/MULT, two-cycle MADD/MSUB and a 32-cycle restoring divider.
// Combinational except the divider FSM, the MADD phase bit and the product temp; stallreq_o holds ID/EX.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        mem_whilo_i,
    input  logic [31:0] mem_hi_i,
    input  logic [31:0] mem_lo_i,
    input  logic        wb_whilo_i,
    input  logic [31:0] wb_hi_i,
    input  logic [31:0] wb_lo_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);
    localparam logic [7:0] OP_AND = 8'b0010_0100, OP_OR = 8'b0010_0101, OP_XOR = 8'b0010_0110,
                           OP_NOR = 8'b0010_0111, OP_SLL = 8'b0111_1100, OP_SRL = 8'b0000_0010,
                           OP_SRA = 8'b0000_0011, OP_MOVZ = 8'b0000_1010, OP_MOVN = 8'b0000_1011,
                           OP_MFHI = 8'b0001_0000, OP_MTHI = 8'b0001_0001, OP_MFLO = 8'b0001_0010,
                           OP_MTLO = 8'b0001_0011, OP_SLT = 8'b0010_1010, OP_SLTU = 8'b0010_1011,
                           OP_ADD = 8'b0010_0000, OP_ADDU = 8'b0010_0001, OP_SUB = 8'b0010_0010,
                           OP_SUBU = 8'b0010_0011, OP_ADDI = 8'b0101_0101, OP_ADDIU = 8'b0101_0110,
                           OP_CLZ = 8'b1011_0000, OP_CLO = 8'b1011_0001, OP_MULT = 8'b0001_1000,
                           OP_MULTU = 8'b0001_1001, OP_MUL = 8'b1010_1001, OP_MADD = 8'b1010_0110,
                           OP_MADDU = 8'b1010_1000, OP_MSUB = 8'b1010_1010, OP_MSUBU = 8'b1010_1011,
                           OP_DIV = 8'b0001_1010, OP_DIVU = 8'b0001_1011;
    localparam logic [2:0] SEL_LOGIC = 3'b001, SEL_SHIFT = 3'b010, SEL_MOVE = 3'b011,
                           SEL_ARITH = 3'b100, SEL_MUL = 3'b101;

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

    div_state_t  div_state, div_nxt;
    logic        div_stall;
    logic [4:0]  div_cnt;
    logic [31:0] div_quo, div_rem, div_dsr;
    logic        div_neg_q, div_neg_r;
    logic        madd_phase;
    logic [63:0] madd_temp;

    logic [31:0] eff_hi, eff_lo, sum, diff, logic_res, shift_res, arith_res, move_res, res;
    logic [31:0] quo_f, rem_f, abs1, abs2;
    logic [63:0] prod_s, prod_u, madd_res;
    logic [5:0]  clz, clo;
    logic [32:0] div_shift, div_trial;
    logic        ov_add, ov_sub, is_madd, madd_signed, is_div, div_signed;

    always_comb begin
        eff_hi = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
        eff_lo = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);
        sum    = reg1_i + reg2_i;
        diff   = reg1_i - reg2_i;
        ov_add = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
        ov_sub = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
        // Low 64 bits of the sign-extended product equal the signed product.
        prod_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
        prod_u = {32'b0, reg1_i} * {32'b0, reg2_i};
        clz = 6'd32;
        clo = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (reg1_i[i])  clz = 6'(31 - i);
            if (!reg1_i[i]) clo = 6'(31 - i);
        end
        is_madd     = (aluop_i == OP_MADD) || (aluop_i == OP_MADDU) ||
                      (aluop_i == OP_MSUB) || (aluop_i == OP_MSUBU);
        madd_signed = (aluop_i == OP_MADD) || (aluop_i == OP_MSUB);
        madd_res    = ((aluop_i == OP_MSUB) || (aluop_i == OP_MSUBU)) ?
                      {eff_hi, eff_lo} - madd_temp : {eff_hi, eff_lo} + madd_temp;
        is_div     = (aluop_i == OP_DIV) || (aluop_i == OP_DIVU);
        div_signed = (aluop_i == OP_DIV);
        abs1 = (div_signed && reg1_i[31]) ? -reg1_i : reg1_i;
        abs2 = (div_signed && reg2_i[31]) ? -reg2_i : reg2_i;
        div_shift = {div_rem, div_quo[31]};
        div_trial = div_shift - {1'b0, div_dsr};
        quo_f = div_neg_q ? -div_quo : div_quo;
        rem_f = div_neg_r ? -div_rem : div_rem;
    end

    always_comb begin
        logic_res = 32'b0;
        shift_res = 32'b0;
        arith_res = 32'b0;
        move_res  = 32'b0;
        case (aluop_i)
            OP_AND: logic_res = reg1_i & reg2_i;
            OP_OR:  logic_res = reg1_i | reg2_i;
            OP_XOR: logic_res = reg1_i ^ reg2_i;
            OP_NOR: logic_res = ~(reg1_i | reg2_i);
            default: logic_res = 32'b0;
        endcase
        case (aluop_i)
            OP_SLL: shift_res = reg2_i << reg1_i[4:0];
            OP_SRL: shift_res = reg2_i >> reg1_i[4:0];
            OP_SRA: shift_res = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            default: shift_res = 32'b0;
        endcase
        case (aluop_i)
            OP_ADD, OP_ADDU, OP_ADDI, OP_ADDIU: arith_res = sum;
            OP_SUB, OP_SUBU: arith_res = diff;
            OP_SLT:  arith_res = {31'b0, $signed(reg1_i) < $signed(reg2_i)};
            OP_SLTU: arith_res = {31'b0, reg1_i < reg2_i};
            OP_CLZ:  arith_res = {26'b0, clz};
            OP_CLO:  arith_res = {26'b0, clo};
            default: arith_res = 32'b0;
        endcase
        case (aluop_i)
            OP_MFHI: move_res = eff_hi;
            OP_MFLO: move_res = eff_lo;
            OP_MOVN, OP_MOVZ: move_res = reg1_i;
            default: move_res = 32'b0;
        endcase
    end

    // Divider next state; the datapath registers below follow the same state.
    always_comb begin
        div_nxt   = div_state;
        div_stall = 1'b0;
        case (div_state)
            DIV_IDLE: if (is_div) begin
                div_stall = 1'b1;
                div_nxt   = (reg2_i == 32'b0) ? DIV_DONE : DIV_RUN;
            end
            DIV_RUN: begin
                div_stall = 1'b1;
                if (div_cnt == 5'd31) div_nxt = DIV_DONE;
            end
            DIV_DONE: div_nxt = DIV_IDLE;
            default:  div_nxt = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_state  <= DIV_IDLE;
            div_cnt    <= 5'b0;
            div_quo    <= 32'b0;
            div_rem    <= 32'b0;
            div_dsr    <= 32'b0;
            div_neg_q  <= 1'b0;
            div_neg_r  <= 1'b0;
            madd_phase <= 1'b0;
            madd_temp  <= 64'b0;
        end else begin
            div_state  <= div_nxt;
            madd_phase <= is_madd ? ~madd_phase : 1'b0;
            if (is_madd && !madd_phase)
                madd_temp <= madd_signed ? prod_s : prod_u;
            case (div_state)
                DIV_IDLE: if (is_div) begin
                    div_cnt   <= 5'b0;
                    div_rem   <= 32'b0;
                    div_quo   <= (reg2_i == 32'b0) ? 32'b0 : abs1;
                    div_dsr   <= abs2;
                    div_neg_q <= div_signed && (reg1_i[31] ^ reg2_i[31]);
                    div_neg_r <= div_signed && reg1_i[31];
                end
                DIV_RUN: begin
                    div_cnt <= div_cnt + 5'd1;
                    div_rem <= div_trial[32] ? div_shift[31:0] : div_trial[31:0];
                    div_quo <= {div_quo[30:0], ~div_trial[32]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (alusel_i)
            SEL_LOGIC: res = logic_res;
            SEL_SHIFT: res = shift_res;
            SEL_MOVE:  res = move_res;
            SEL_ARITH: res = arith_res;
            SEL_MUL:   res = prod_s[31:0];
            default:   res = 32'b0;
        endcase
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = res;
        whilo_o    = 1'b0;
        hi_o       = 32'b0;
        lo_o       = 32'b0;
        stallreq_o = div_stall || (is_madd && !madd_phase);
        if ((((aluop_i == OP_ADD) || (aluop_i == OP_ADDI)) && ov_add) ||
            ((aluop_i == OP_SUB) && ov_sub))
            wreg_o = 1'b0;
        if (aluop_i == OP_MULT) begin
            whilo_o = 1'b1;
            {hi_o, lo_o} = prod_s;
        end else if (aluop_i == OP_MULTU) begin
            whilo_o = 1'b1;
            {hi_o, lo_o} = prod_u;
        end else if (is_madd && madd_phase) begin
            whilo_o = 1'b1;
            {hi_o, lo_o} = madd_res;
        end else if (aluop_i == OP_MTHI) begin
            whilo_o = 1'b1;
            hi_o    = reg1_i;
            lo_o    = eff_lo;
        end else if (aluop_i == OP_MTLO) begin
            whilo_o = 1'b1;
            hi_o    = eff_hi;
            lo_o    = reg1_i;
        end else if (div_state == DIV_DONE) begin
            whilo_o = 1'b1;
            hi_o    = rem_f;
            lo_o    = quo_f;
        end
        if (rst) begin
            wd_o       = 5'b0;
            wreg_o     = 1'b0;
            wdata_o    = 32'b0;
            whilo_o    = 1'b0;
            hi_o       = 32'b0;
            lo_o       = 32'b0;
            stallreq_o = 1'b0;
        end
    end
endmodule
